// File: rtl/ttl160_divider_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ttl160_divider_ctrl_if
// Description : Configuration / control bundle between the register side and
//               the divide-by-M sequencer for a 74x160 decade counter chain.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals
//   cfg_valid    master->slave  new configuration offered
//   cfg_ready    slave->master  configuration can be taken (IDLE only)
//   cfg_m        master->slave  modulus M, BCD, digit 0 in bits [3:0]
//   cfg_periodic master->slave  1 = reload forever, 0 = one-shot
//   start        master->slave  single-cycle start request
//   stop         master->slave  single-cycle abort request
//   busy         slave->master  sequencer not idle
//   tick         slave->master  one-cycle pulse per completed period
//   cfg_err      slave->master  sticky: last offered config was rejected
// ============================================================================
interface ttl160_divider_ctrl_if #(
    parameter int DIGITS = 3
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [4*DIGITS-1:0]   cfg_m;
    logic                  cfg_periodic;
    logic                  start;
    logic                  stop;
    logic                  busy;
    logic                  tick;
    logic                  cfg_err;

    modport master (
        output cfg_valid, cfg_m, cfg_periodic, start, stop,
        input  cfg_ready, busy, tick, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_m, cfg_periodic, start, stop,
        output cfg_ready, busy, tick, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/ttl160_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ttl160_divider_ctrl
// Description : Sequencer for a cascade of DIGITS 74x160 decade counters used
//               as a programmable divide-by-M BCD timer. Computes the preload
//               L = 10^DIGITS - M one digit per cycle, loads the chain and then
//               drives PE_n/CEP/CET so the chain ticks once every M clocks.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      rising-edge clock shared with the counters
//   MR_n     asynchronous active-low reset, shared with the counters
//   cfg_if   configuration/control bundle (slave side)
//   pe_n     parallel enable to all counters
//   cep      count enable P to all counters
//   cet0     count enable T of digit 0
//   p        preload value L, BCD
//   tc_last  terminal count of the most significant digit
// ============================================================================
module ttl160_divider_ctrl #(
    parameter int DIGITS = 3
) (
    input  wire logic                 clk,
    input  wire logic                 MR_n,
    ttl160_divider_ctrl_if.slave      cfg_if,
    output logic                      pe_n,
    output logic                      cep,
    output logic                      cet0,
    output logic [4*DIGITS-1:0]       p,
    input  wire logic                 tc_last
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_LOAD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   m_q, m_d;
    logic                  periodic_q, periodic_d;
    logic                  cfg_ok_q, cfg_ok_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [4*DIGITS-1:0]   p_q, p_d;
    logic                  carry_q, carry_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick_q, tick_d;

    logic                  cfg_bad;
    logic [3:0]            m_digit;
    logic [4:0]            digit_sum;
    logic [3:0]            p_digit;

    always_comb begin
        cfg_bad = (cfg_if.cfg_m == '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (cfg_if.cfg_m[i*4 +: 4] > 4'd9) begin
                cfg_bad = 1'b1;
            end
        end
    end

    // Ten's complement of the current digit: 9 - m_k + carry, wrapping 10 to 0.
    always_comb begin
        m_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                m_digit = m_q[i*4 +: 4];
            end
        end
        digit_sum = 5'd9 - {1'b0, m_digit} + {4'b0, carry_q};
        p_digit   = (digit_sum == 5'd10) ? 4'd0 : digit_sum[3:0];
    end

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        periodic_d = periodic_q;
        cfg_ok_d   = cfg_ok_q;
        cfg_err_d  = cfg_err_q;
        p_d        = p_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        tick_d     = 1'b0;
        pe_n       = 1'b1;
        cep        = 1'b0;
        cet0       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_if.cfg_valid) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        m_d        = cfg_if.cfg_m;
                        periodic_d = cfg_if.cfg_periodic;
                        cfg_ok_d   = 1'b1;
                        cfg_err_d  = 1'b0;
                    end
                end
                // cfg_ok_d so a config offered in the same cycle counts.
                if (cfg_if.start && cfg_ok_d) begin
                    state_d = S_CALC;
                    carry_d = 1'b1;
                    idx_d   = '0;
                end
            end
            S_CALC: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        p_d[i*4 +: 4] = p_digit;
                    end
                end
                carry_d = (digit_sum == 5'd10);
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_LOAD: begin
                pe_n    = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cet0 = 1'b1;
                // CEP is dropped on the leaving edge (one-shot end or abort) so
                // the chain holds its value instead of wrapping past all-9s.
                // CET stays high: TC depends on it, gating it would loop.
                cep  = ~cfg_if.stop & (periodic_q | ~tc_last);
                pe_n = ~(tc_last & periodic_q & ~cfg_if.stop);
                if (tc_last) begin
                    tick_d = 1'b1;
                    if (!periodic_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a coincident terminal count.
        if (cfg_if.stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            tick_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            periodic_q <= 1'b0;
            cfg_ok_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            p_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            periodic_q <= periodic_d;
            cfg_ok_q   <= cfg_ok_d;
            cfg_err_q  <= cfg_err_d;
            p_q        <= p_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
        end
    end

    assign p                = p_q;
    assign cfg_if.cfg_ready = (state_q == S_IDLE);
    assign cfg_if.busy      = (state_q != S_IDLE);
    assign cfg_if.tick      = tick_q;
    assign cfg_if.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ttl160_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttl160_divider_ctrl
// Description : Self-checking bench for ttl160_divider_ctrl. A behavioural
//               model of the 74x160 chain (an integer modulo 10^DIGITS) closes
//               the loop; expectations come from L = 10^DIGITS - M and the
//               tick timing rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ttl160_divider_ctrl;

    localparam int D   = 3;
    localparam int MOD = 10 ** D;

    logic            clk;
    logic            MR_n;
    logic            pe_n;
    logic            cep;
    logic            cet0;
    logic [4*D-1:0]  p;
    logic            tc_last;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    ttl160_divider_ctrl_if #(.DIGITS(D)) bus ();

    ttl160_divider_ctrl #(.DIGITS(D)) dut (
        .clk     (clk),
        .MR_n    (MR_n),
        .cfg_if  (bus),
        .pe_n    (pe_n),
        .cep     (cep),
        .cet0    (cet0),
        .p       (p),
        .tc_last (tc_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [4*D-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] int2bcd(input int v);
        logic [4*D-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Counter chain: synchronous load, count when CEP & CET, async clear.
    always @(posedge clk or negedge MR_n) begin
        if (!MR_n)          cnt <= 0;
        else if (!pe_n)     cnt <= bcd2int(p);
        else if (cep && cet0) cnt <= (cnt + 1) % MOD;
    end
    assign tc_last = cet0 && (cnt == MOD - 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: config then start, 1: config and start together, 2: start only.
    // Edge 0 is the edge that samples start. p is complete after edge D, the
    // chain holds L after edge D+1, and tick is visible after edge D+M+1
    // (captured downstream at edge D+M+2), then every M edges if periodic.
    task automatic run_case(input int m, input bit per, input int mode);
        int L     = MOD - m;
        int first = D + m + 1;
        int win   = per ? first + 2 * m + 1 : first + 3;
        bit exp_tick;
        if (mode != 2) begin
            bus.cfg_m        = int2bcd(m);
            bus.cfg_periodic = per;
            bus.cfg_valid    = 1'b1;
        end
        if (mode == 0) begin
            step();
            bus.cfg_valid = 1'b0;
            check("cfg_err_clear", bus.cfg_err, 0);
        end
        bus.start = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        check("busy_after_start", bus.busy, 1);
        for (int k = 1; k <= win; k++) begin
            step();
            if (k == D)     check("p_preload", p, int2bcd(L));
            if (k == D + 1) check("chain_loaded", cnt, L);
            exp_tick = per ? (k >= first && ((k - first) % m) == 0) : (k == first);
            check("tick", bus.tick, exp_tick);
            if (!per) check("busy_oneshot", bus.busy, (k < first));
        end
        if (!per) begin
            check("oneshot_hold", cnt, MOD - 1);
            check("oneshot_cep", cep, 0);
        end else begin
            bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
            check("stop_busy", bus.busy, 0);
            check("stop_cep", cep, 0);
        end
    endtask

    initial begin
        int  m;
        bit  per;
        bit  seen;
        MR_n             = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_m        = '0;
        bus.cfg_periodic = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;

        #3;
        check("rst_pe_n", pe_n, 1);
        check("rst_cep", cep, 0);
        check("rst_cet0", cet0, 0);
        check("rst_p", p, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        step();
        MR_n = 1'b1;
        step();

        // start with nothing configured is ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_no_cfg", bus.busy, 0);

        // rejected configurations
        bus.cfg_m = 12'h0A5; bus.cfg_valid = 1'b1; step(); bus.cfg_valid = 1'b0;
        check("err_nibble", bus.cfg_err, 1);
        bus.cfg_m = 12'h000; bus.cfg_valid = 1'b1; step(); bus.cfg_valid = 1'b0;
        check("err_zero", bus.cfg_err, 1);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("start_after_reject", bus.busy, 0);
        step();
        check("still_idle", bus.busy, 0);

        run_case(25, 1'b1, 0);

        // a rejected config must leave the stored M=025 in place
        bus.cfg_m = 12'h0A5; bus.cfg_valid = 1'b1; step(); bus.cfg_valid = 1'b0;
        check("err_keeps_m", bus.cfg_err, 1);
        run_case(25, 1'b1, 2);

        run_case(1, 1'b1, 0);
        run_case(999, 1'b1, 0);
        run_case(10, 1'b0, 0);
        run_case(4, 1'b1, 1);

        repeat (4) begin
            m   = int'($urandom_range(1, 150));
            per = 1'(($urandom() & 1));
            run_case(m, per, 0);
        end

        // stop coincident with terminal count
        bus.cfg_m = int2bcd(25); bus.cfg_periodic = 1'b1; bus.cfg_valid = 1'b1;
        bus.start = 1'b1;
        step();
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            seen = tc_last;
        end
        check("tc_wait", seen, 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop_tc_tick", bus.tick, 0);
        check("stop_tc_busy", bus.busy, 0);
        check("stop_tc_cep", cep, 0);
        check("stop_tc_hold", cnt, MOD - 1);

        // asynchronous reset in the middle of CALC
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2;
        MR_n = 1'b0;
        #1;
        check("mr_busy", bus.busy, 0);
        check("mr_p", p, 0);
        check("mr_pe_n", pe_n, 1);
        check("mr_cep", cep, 0);
        check("mr_cet0", cet0, 0);
        check("mr_tick", bus.tick, 0);
        check("mr_cfg_ready", bus.cfg_ready, 1);
        check("mr_cfg_err", bus.cfg_err, 0);
        step();
        MR_n = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("mr_cfg_ok_cleared", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ttl160_divider_ctrl.md
# ttl160_divider_ctrl

Sequencing controller for a cascade of DIGITS TTL74x160a decade counters, wired as a programmable divide-by-M BCD timer. It accepts a BCD modulus M over a valid/ready handshake and computes the preload value L = 10^DIGITS − M digit by digit. It then drives the chain's PE_n/CEP/CET/P so the chain emits one tick every M clocks, either periodically or once. It sits between the register/config logic and the counter instances; the counters' Q and the last TC feed back into it.

## Interface
- DIGITS, 3, number of cascaded decade counters (1..6)
- clk  in  1  rising-edge clock, shared with all counter instances
- MR_n  in  1  asynchronous active-low reset; also wired to the counters' MR_n
- cfg_valid  in  1  new config offered
- cfg_ready  out  1  high in IDLE only
- cfg_m  in  4*DIGITS  modulus M, BCD, digit 0 in bits [3:0]
- cfg_periodic  in  1  1 = reload forever, 0 = one-shot
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- pe_n  out  1  to all counters' PE_n
- cep  out  1  to all counters' CEP
- cet0  out  1  to digit 0 CET; digit k CET = digit k−1 TC (external wiring)
- p  out  4*DIGITS  preload value L, BCD, to counters' P
- tc_last  in  1  TC of digit DIGITS−1
- busy  out  1  state ≠ IDLE
- tick  out  1  one-cycle pulse per completed modulus period
- cfg_err  out  1  sticky: last offered config was rejected

## Operation
- States: IDLE, CALC, LOAD, RUN.
- IDLE:
  - cfg_valid & cfg_ready accepts the config.
  - The config is rejected (cfg_err←1, stored config unchanged) if any nibble is >9 or M == 0. Otherwise it is stored, a cfg_ok flag is set, and cfg_err←0.
- IDLE, start & cfg_ok → CALC. start without cfg_ok is ignored.
  - cfg_valid and start in the same cycle: the config is accepted first, and start uses the new M only if that config is valid.
- CALC: DIGITS cycles, one digit per cycle from digit 0, computing the ten's complement with a carry.
  - p_k = 9 − m_k + c; if the result is 10, p_k = 0 and c = 1, else c = 0.
  - c starts at 1.
  - After the last digit → LOAD.
- LOAD: one cycle with pe_n = 0, cep = cet0 = 0. The counters load L at the edge. → RUN.
- RUN: cep = cet0 = 1.
  - pe_n = ~(tc_last & cfg_periodic), combinational, so a periodic chain reloads L on the edge after terminal count.
  - tc_last in RUN sets the registered tick in the next cycle.
  - One-shot: tc_last → IDLE. cep drops with the state and the chain holds all-9s.
- stop in CALC/LOAD/RUN → IDLE at the next edge. No tick is generated, and tick is suppressed even if tc_last coincides. The counters hold their value.
- stop in IDLE has no effect.
- start outside IDLE is ignored.
- p holds the last computed L outside CALC and is only updated during CALC.

## Timing
- Reset (MR_n low, asynchronous) forces:
  - state IDLE, pe_n = 1, cep = 0, cet0 = 0, p = 0
  - tick = 0, busy = 0, cfg_err = 0, cfg_ok = 0, cfg_ready = 1
- Reset mid-run aborts immediately; counters clear via the shared MR_n.
- Start latency: start accepted at edge t → CALC edges t+1..t+DIGITS → LOAD → RUN.
- Counter values during RUN: L, L+1, …, all-9s, one per clock. First tick is DIGITS+M+2 cycles after the start edge.
- Periodic mode: period is exactly M clocks with no dead cycle.
  - M = 1 gives L = all-9s: tc_last is high every RUN cycle and tick stays high continuously.
- M = 10^DIGITS−1 gives L = 0…01.

## Test plan
- DIGITS=3, cfg M=025 periodic, start:
  - after the CALC/LOAD cycles p=975, counters walk 975..999 then 975.
  - tick every 25 cycles; first tick 30 cycles after start.
- M=001 periodic → p=999, tick held high every cycle in RUN. M=999 → p=001, period 999.
- One-shot M=010 → p=990, single tick 15 cycles after start; busy falls in the same cycle the tick rises; Q stays 999.
- cfg M=0A5 → cfg_err=1 and M is unchanged; cfg M=000 → cfg_err=1; a following start with no valid config → busy stays 0.
- stop in RUN coincident with tc_last → no tick, IDLE next cycle, cep=0. MR_n low mid-CALC → all outputs at reset values immediately.
- cfg_valid (M=004) and start in the same IDLE cycle → runs with 004 (p=996).
